uart_flow: RTL and testbench

//  Byte-serial UART transceiver sitting directly behind the Wishbone flow port.

---
 rtl/uart_flow.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_flow.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_flow.sv
// UART transceiver with valid/ready flow ports: TX serializer and RX deframer
// with a one-entry holding register, both clocked by the bus clock.
module uart_flow #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  rx_overrun,
   output logic                  rx_frame_err,
   output logic                  txd,
   input  logic                  rxd
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_cpb
      $error("uart_flow: CLKS_PER_BIT must be at least 4");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t                tx_state_r, tx_state_s;
   logic [CW-1:0]         tx_cnt_r, tx_cnt_s;
   logic [BW-1:0]         tx_bit_r, tx_bit_s;
   logic [DATA_WIDTH-1:0] tx_shift_r, tx_shift_s;
   logic                  txd_r, txd_s;
   logic                  tx_ready_r, tx_ready_s;

   // TX next-state: txd is registered, so each bit value is set one edge ahead
   always_comb begin
      tx_state_s = tx_state_r;
      tx_cnt_s   = tx_cnt_r;
      tx_bit_s   = tx_bit_r;
      tx_shift_s = tx_shift_r;
      txd_s      = txd_r;
      tx_ready_s = tx_ready_r;
      case (tx_state_r)
         ST_IDLE: begin
            if (tx_valid && tx_ready_r) begin
               tx_state_s = ST_START;
               tx_shift_s = tx_data;
               tx_cnt_s   = '0;
               tx_bit_s   = '0;
               txd_s      = 1'b0;
               tx_ready_s = 1'b0;
            end else begin
               txd_s      = 1'b1;
               tx_ready_s = 1'b1;
            end
         end
         ST_START: begin
            if (tx_cnt_r == CNT_LAST) begin
               tx_state_s = ST_DATA;
               tx_cnt_s   = '0;
               txd_s      = tx_shift_r[0];
            end else begin
               tx_cnt_s = tx_cnt_r + CNT_ONE;
            end
         end
         ST_DATA: begin
            if (tx_cnt_r == CNT_LAST) begin
               tx_cnt_s = '0;
               if (tx_bit_r == BIT_LAST) begin
                  tx_state_s = ST_STOP;
                  txd_s      = 1'b1;
               end else begin
                  tx_bit_s   = tx_bit_r + BIT_ONE;
                  tx_shift_s = {1'b0, tx_shift_r[DATA_WIDTH-1:1]};
                  txd_s      = tx_shift_r[1];
               end
            end else begin
               tx_cnt_s = tx_cnt_r + CNT_ONE;
            end
         end
         ST_STOP: begin
            if (tx_cnt_r == CNT_LAST) begin
               tx_state_s = ST_IDLE;
               tx_cnt_s   = '0;
               tx_ready_s = 1'b1;
            end else begin
               tx_cnt_s = tx_cnt_r + CNT_ONE;
            end
         end
         default: begin
            tx_state_s = ST_IDLE;
            tx_cnt_s   = '0;
            txd_s      = 1'b1;
            tx_ready_s = 1'b1;
         end
      endcase
   end

   // TX state register
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_r <= ST_IDLE;
         tx_cnt_r   <= '0;
         tx_bit_r   <= '0;
         tx_shift_r <= '0;
         txd_r      <= 1'b1;
         tx_ready_r <= 1'b1;
      end else begin
         tx_state_r <= tx_state_s;
         tx_cnt_r   <= tx_cnt_s;
         tx_bit_r   <= tx_bit_s;
         tx_shift_r <= tx_shift_s;
         txd_r      <= txd_s;
         tx_ready_r <= tx_ready_s;
      end
   end

   logic                  rx_meta_r, rxs_r;
   state_t                rx_state_r, rx_state_s;
   logic [CW-1:0]         rx_cnt_r, rx_cnt_s;
   logic [BW-1:0]         rx_bit_r, rx_bit_s;
   logic [DATA_WIDTH-1:0] rx_shift_r, rx_shift_s;
   logic [DATA_WIDTH-1:0] rx_data_r, rx_data_s;
   logic                  rx_valid_r, rx_valid_s;
   logic                  rx_overrun_r, rx_overrun_s;
   logic                  rx_frame_err_r, rx_frame_err_s;

   // Two-flop synchronizer for the asynchronous serial input
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_r <= 1'b1;
         rxs_r     <= 1'b1;
      end else begin
         rx_meta_r <= rxd;
         rxs_r     <= rx_meta_r;
      end
   end

   // RX next-state: samples at mid-bit, delivers into the holding register at stop
   always_comb begin
      rx_state_s     = rx_state_r;
      rx_cnt_s       = rx_cnt_r;
      rx_bit_s       = rx_bit_r;
      rx_shift_s     = rx_shift_r;
      rx_data_s      = rx_data_r;
      rx_overrun_s   = 1'b0;
      rx_frame_err_s = 1'b0;
      if (rx_valid_r && rx_ready) begin
         rx_valid_s = 1'b0;
      end else begin
         rx_valid_s = rx_valid_r;
      end
      case (rx_state_r)
         ST_IDLE: begin
            rx_cnt_s = '0;
            rx_bit_s = '0;
            if (!rxs_r) begin
               rx_state_s = ST_START;
            end else begin
               rx_state_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (rx_cnt_r == CNT_MID) begin
               rx_cnt_s = '0;
               if (!rxs_r) begin
                  rx_state_s = ST_DATA;
               end else begin
                  rx_state_s = ST_IDLE;
               end
            end else begin
               rx_cnt_s = rx_cnt_r + CNT_ONE;
            end
         end
         ST_DATA: begin
            if (rx_cnt_r == CNT_LAST) begin
               rx_cnt_s   = '0;
               rx_shift_s = {rxs_r, rx_shift_r[DATA_WIDTH-1:1]};
               if (rx_bit_r == BIT_LAST) begin
                  rx_state_s = ST_STOP;
               end else begin
                  rx_bit_s = rx_bit_r + BIT_ONE;
               end
            end else begin
               rx_cnt_s = rx_cnt_r + CNT_ONE;
            end
         end
         ST_STOP: begin
            if (rx_cnt_r == CNT_LAST) begin
               rx_state_s = ST_IDLE;
               rx_cnt_s   = '0;
               if (!rxs_r) begin
                  rx_frame_err_s = 1'b1;
               end else if (!rx_valid_r || rx_ready) begin
                  rx_data_s  = rx_shift_r;
                  rx_valid_s = 1'b1;
               end else begin
                  rx_overrun_s = 1'b1;
               end
            end else begin
               rx_cnt_s = rx_cnt_r + CNT_ONE;
            end
         end
         default: begin
            rx_state_s = ST_IDLE;
            rx_cnt_s   = '0;
         end
      endcase
   end

   // RX state and holding register
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_r     <= ST_IDLE;
         rx_cnt_r       <= '0;
         rx_bit_r       <= '0;
         rx_shift_r     <= '0;
         rx_data_r      <= '0;
         rx_valid_r     <= 1'b0;
         rx_overrun_r   <= 1'b0;
         rx_frame_err_r <= 1'b0;
      end else begin
         rx_state_r     <= rx_state_s;
         rx_cnt_r       <= rx_cnt_s;
         rx_bit_r       <= rx_bit_s;
         rx_shift_r     <= rx_shift_s;
         rx_data_r      <= rx_data_s;
         rx_valid_r     <= rx_valid_s;
         rx_overrun_r   <= rx_overrun_s;
         rx_frame_err_r <= rx_frame_err_s;
      end
   end

   assign txd          = txd_r;
   assign tx_ready     = tx_ready_r;
   assign rx_data      = rx_data_r;
   assign rx_valid     = rx_valid_r;
   assign rx_overrun   = rx_overrun_r;
   assign rx_frame_err = rx_frame_err_r;
endmodule

// File: tb/tb_uart_flow.sv
// Scoreboard bench for uart_flow at CLKS_PER_BIT=4, DATA_WIDTH=8: directed
// stimulus pushes expected RX events, an independent monitor checks them.
module tb_uart_flow;
   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       rx_overrun;
   logic       rx_frame_err;
   logic       txd;
   logic       rxd;
   logic       rxd_drv = 1'b1;
   logic       loop_en = 1'b0;

   assign rxd = loop_en ? txd : rxd_drv;

   uart_flow #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
      .txd(txd), .rxd(rxd)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail = 0;
   int         n_pulse = 0;
   int         exp_ovr = 0;
   int         exp_ferr = 0;
   logic [7:0] exp_data[$];
   bit         mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // RX monitor: pops the scoreboard on every consumed byte or error pulse
   always @(negedge clk) begin
      if (mon_en) begin
         if (rx_valid && rx_ready) begin
            if (exp_data.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rx_unexpected_byte: got 0x%0h, expected no byte", rx_data);
            end else begin
               chk("rx_data", 32'(rx_data), 32'(exp_data.pop_front()));
            end
         end
         if (rx_overrun) begin
            n_pulse++;
            chk("rx_overrun_expected", 32'(exp_ovr > 0), 32'd1);
            if (exp_ovr > 0) exp_ovr--;
         end
         if (rx_frame_err) begin
            n_pulse++;
            chk("rx_frame_err_expected", 32'(exp_ferr > 0), 32'd1);
            if (exp_ferr > 0) exp_ferr--;
         end
      end
   end

   task automatic send(input logic [7:0] b);
      bit got;
      got = 1'b0;
      tx_data  = b;
      tx_valid = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (tx_ready) got = 1'b1;
      end
      chk("tx_accept", 32'(got), 32'd1);
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_data  = ~b;
   endtask

   // Called in cycle N+1 after the accept edge; exp[0] is the first bit on the wire.
   task automatic check_tx_frame(input logic [9:0] exp);
      for (int k = 0; k < 10 * CPB; k++) begin
         @(negedge clk);
         if (k == 0) chk("tx_ready_busy", 32'(tx_ready), 32'd0);
         chk($sformatf("txd_bit%0d_cyc%0d", k / CPB, k), 32'(txd), 32'(exp[k / CPB]));
      end
      @(negedge clk);
      chk("tx_ready_done", 32'(tx_ready), 32'd1);
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd_drv = fr[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      rxd_drv = 1'b1;
   endtask

   task automatic wait_drain(input string name, input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (exp_data.size() == 0 && exp_ovr == 0 && exp_ferr == 0) break;
         @(negedge clk);
      end
      chk(name, 32'(exp_data.size() + exp_ovr + exp_ferr), 32'd0);
   endtask

   initial begin
      int bad;
      int lat;
      int pulses_before;

      // 1: reset state and quiet idle line
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_txd", 32'(txd), 32'd1);
      chk("rst_tx_ready", 32'(tx_ready), 32'd1);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (txd !== 1'b1 || tx_ready !== 1'b1 || rx_valid !== 1'b0 ||
             rx_overrun !== 1'b0 || rx_frame_err !== 1'b0) bad++;
      end
      chk("idle_quiet", 32'(bad), 32'd0);

      // 2: 0xA5 framed cycle-exactly: 0,1,0,1,0,0,1,0,1,1
      @(posedge clk); #1;
      send(8'hA5);
      check_tx_frame(10'b1101001010);

      // 3: loopback 0x3C, byte presented 42 cycles after accept
      @(posedge clk); #1;
      loop_en  = 1'b1;
      rx_ready = 1'b1;
      exp_data.push_back(8'h3C);
      send(8'h3C);
      lat = 0;
      for (int k = 1; k <= 80 && lat == 0; k++) begin
         @(negedge clk);
         if (rx_valid) lat = k;
      end
      chk("rx_latency", 32'(lat), 32'd42);
      wait_drain("loop_3c_drain", 20);

      // 4: overrun with holding register full
      @(posedge clk); #1;
      rx_ready = 1'b0;
      exp_data.push_back(8'h11);
      exp_ovr++;
      send(8'h11);
      send(8'h22);
      for (int i = 0; i < 100 && exp_ovr != 0; i++) @(negedge clk);
      chk("ovr_seen", 32'(exp_ovr), 32'd0);
      repeat (5) @(negedge clk);
      chk("ovr_rx_valid_held", 32'(rx_valid), 32'd1);
      chk("ovr_rx_data_kept", 32'(rx_data), 32'h11);
      @(posedge clk); #1 rx_ready = 1'b1;
      @(posedge clk); #1 rx_ready = 1'b0;
      @(negedge clk);
      chk("consume_clears_valid", 32'(rx_valid), 32'd0);
      wait_drain("ovr_drain", 10);

      // 5: glitch rejection, framing error, then a good frame
      loop_en = 1'b0;
      @(posedge clk); #1;
      pulses_before = n_pulse;
      rxd_drv = 1'b0;
      @(posedge clk); #1 rxd_drv = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("glitch_no_pulse", 32'(n_pulse - pulses_before), 32'd0);
      chk("glitch_no_byte", 32'(rx_valid), 32'd0);
      exp_ferr++;
      rx_frame(8'h55, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      chk("ferr_seen", 32'(exp_ferr), 32'd0);
      chk("ferr_no_byte", 32'(rx_valid), 32'd0);
      rx_ready = 1'b1;
      exp_data.push_back(8'h0F);
      rx_frame(8'h0F, 1'b1);
      wait_drain("good_after_ferr", 20);

      // 6: reset 10 cycles into a TX frame, then a fresh frame 0xC3
      rx_ready = 1'b0;
      @(posedge clk); #1;
      send(8'h81);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_txd", 32'(txd), 32'd1);
      chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
      send(8'hC3);
      check_tx_frame(10'b1110000110);

      repeat (5) @(negedge clk);
      wait_drain("final_drain", 5);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
      $fatal(1, "timeout");
   end
endmodule
